// File: rtl/if_id_buffer.sv
// IF/ID pipeline register with a one-entry skid buffer so the decode view stays steady
// under stall while an in-flight fetch response is still captured.
module if_id_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pc_next,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        flush,
  output logic        if_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_next,
  output logic [31:0] id_instr,
  output logic        skid_full
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e      state_q;
  logic [31:0] skid_pc;
  logic [31:0] skid_pc_next;
  logic [31:0] skid_instr;
  logic        fetch_done;

  assign skid_full  = (state_q == StFull);
  // A response is only consumed while the skid slot is free; otherwise the source holds it.
  assign fetch_done = if_valid & imem_resp & ~skid_full;
  assign if_stall   = skid_full | (if_valid & ~imem_resp) | (id_stall & fetch_done & skid_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StEmpty;
      id_valid     <= 1'b0;
      id_pc        <= PC_RESET;
      id_pc_next   <= PC_RESET;
      id_instr     <= NOP_INSTR;
      skid_pc      <= PC_RESET;
      skid_pc_next <= PC_RESET;
      skid_instr   <= NOP_INSTR;
    end else if (flush) begin
      // PCs are left alone so trace data of the squashed slot stays meaningful.
      state_q  <= StEmpty;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (!id_stall) begin
      if (state_q == StFull) begin
        state_q    <= StEmpty;
        id_valid   <= 1'b1;
        id_pc      <= skid_pc;
        id_pc_next <= skid_pc_next;
        id_instr   <= skid_instr;
      end else if (fetch_done) begin
        id_valid   <= 1'b1;
        id_pc      <= if_pc;
        id_pc_next <= if_pc_next;
        id_instr   <= imem_rdata;
      end else begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
    end else if ((state_q == StEmpty) && fetch_done) begin
      state_q      <= StFull;
      skid_pc      <= if_pc;
      skid_pc_next <= if_pc_next;
      skid_instr   <= imem_rdata;
    end
  end

endmodule
